// File: rtl/mem_access_if.sv
// Data-memory req/ack port between the mem_access stage (master) and the data memory (slave).
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wstrb, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wstrb, wdata, output rdata, ack);
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: load/store over a req/ack port with lane steering and extension.
// Optional macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing alignment.
module mem_access #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic         is_load,
    input  logic         is_store,
    input  logic [2:0]   funct3,
    input  logic [31:0]  alu_result,
    input  logic [31:0]  store_data,
    input  logic [4:0]   rd_in,
    input  logic         reg_we_in,
    output logic         valid_out,
    output logic [31:0]  wb_data,
    output logic [4:0]   rd_out,
    output logic         reg_we_out,
    mem_access_if.master dmem,
    output logic         bus_err,
    output logic         misalign_err
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_REQ    = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic [15:0] CNT_LAST = 16'(WAIT_MAX - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_we_q, reg_we_d;
    logic        bus_err_q, bus_err_d;
    logic        mis_q, mis_d;
    logic        req_q, req_d;
    logic        dwe_q, dwe_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic        pend_we_q, pend_we_d;

    logic [1:0]  a_lo;
    logic        is_mem;
    logic        f3_legal;
    logic        mis_hit;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign a_lo   = alu_result[1:0];
    assign is_mem = is_load | is_store;

    always_comb begin
        f3_legal = 1'b0;
        if (is_store)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end

`ifdef MISALIGN_TRAP_EN
    assign mis_hit = f3_legal &&
                     (((funct3[1:0] == 2'b01) && a_lo[0]) ||
                      ((funct3[1:0] == 2'b10) && (a_lo != 2'b00)));
`else
    assign mis_hit = 1'b0;
`endif

    // Without the trap, halfword steering looks at a[1] only and word ignores a.
    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << a_lo;
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb  = a_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem.rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        ld_val  = dmem.rdata;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = dmem.rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        bus_err_d = 1'b0;
        mis_d     = 1'b0;
        reg_we_d  = 1'b0;
        wb_data_d = wb_data_q;
        rd_d      = rd_q;
        req_d     = req_q;
        dwe_d     = dwe_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        pend_rd_d = pend_rd_q;
        pend_we_d = pend_we_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    ready_d = 1'b0;
                    if (!is_mem) begin
                        state_d   = S_RESP;
                        valid_d   = 1'b1;
                        wb_data_d = alu_result;
                        rd_d      = rd_in;
                        reg_we_d  = reg_we_in;
                    end else if (!f3_legal || mis_hit) begin
                        // Faulting access: report the address on a trap, zero otherwise.
                        state_d   = S_RESP;
                        valid_d   = 1'b1;
                        wb_data_d = mis_hit ? alu_result : 32'h0;
                        rd_d      = rd_in;
                        mis_d     = mis_hit;
                    end else begin
                        state_d   = S_REQ;
                        cnt_d     = 16'h0;
                        req_d     = 1'b1;
                        dwe_d     = is_store;
                        addr_d    = {alu_result[31:2], 2'b00};
                        strb_d    = is_store ? st_strb : 4'b0000;
                        wdata_d   = is_store ? st_wdata : 32'h0;
                        f3_d      = funct3;
                        lo_d      = a_lo;
                        pend_rd_d = rd_in;
                        pend_we_d = is_load & reg_we_in;
                    end
                end
            end
            S_REQ: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (dmem.ack) begin
                    req_d     = 1'b0;
                    state_d   = S_RESP;
                    valid_d   = 1'b1;
                    rd_d      = pend_rd_q;
                    reg_we_d  = pend_we_q;
                    wb_data_d = dwe_q ? 32'h0 : ld_val;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    state_d   = S_RESP;
                    valid_d   = 1'b1;
                    bus_err_d = 1'b1;
                    rd_d      = pend_rd_q;
                    wb_data_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                cnt_d   = 16'h0;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'h0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            wb_data_q <= 32'h0;
            rd_q      <= 5'h0;
            reg_we_q  <= 1'b0;
            bus_err_q <= 1'b0;
            mis_q     <= 1'b0;
            req_q     <= 1'b0;
            dwe_q     <= 1'b0;
            addr_q    <= 32'h0;
            strb_q    <= 4'h0;
            wdata_q   <= 32'h0;
            f3_q      <= 3'h0;
            lo_q      <= 2'h0;
            pend_rd_q <= 5'h0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            wb_data_q <= wb_data_d;
            rd_q      <= rd_d;
            reg_we_q  <= reg_we_d;
            bus_err_q <= bus_err_d;
            mis_q     <= mis_d;
            req_q     <= req_d;
            dwe_q     <= dwe_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            pend_rd_q <= pend_rd_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign ready_out    = ready_q;
    assign valid_out    = valid_q;
    assign wb_data      = wb_data_q;
    assign rd_out       = rd_q;
    assign reg_we_out   = reg_we_q;
    assign bus_err      = bus_err_q;
    assign misalign_err = mis_q;
    assign dmem.req     = req_q;
    assign dmem.we      = dwe_q;
    assign dmem.addr    = addr_q;
    assign dmem.wstrb   = strb_q;
    assign dmem.wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a per-cycle expected-output timeline built from transaction rules,
// compared every cycle, plus literal checks from the worked examples.
module tb_mem_access;
    localparam int WAIT = 4;
    localparam int N    = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, ready_out, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data, wb_data;
    logic [4:0]  rd_in, rd_out;
    logic        reg_we_in, valid_out, reg_we_out, bus_err, misalign_err;

    mem_access_if dmem();

    mem_access #(.WAIT_MAX(WAIT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
        .reg_we_in(reg_we_in), .valid_out(valid_out), .wb_data(wb_data),
        .rd_out(rd_out), .reg_we_out(reg_we_out), .dmem(dmem),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // Expected timeline, indexed by cycle number (cycle c follows posedge number c).
    logic        e_ready [N];
    logic        e_req   [N];
    logic        e_dwe   [N];
    logic [31:0] e_addr  [N];
    logic [3:0]  e_strb  [N];
    logic [31:0] e_wdata [N];
    logic        e_valid [N];
    logic        e_wbchk [N];
    logic [31:0] e_wb    [N];
    logic [4:0]  e_rd    [N];
    logic        e_rwe   [N];
    logic        e_berr  [N];
    logic        e_mis   [N];

    logic [31:0] last_wb, last_addr, last_wdata;
    logic [4:0]  last_rd;
    logic [3:0]  last_strb;
    logic        last_rwe, last_berr, last_mis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[8*a +: 8];
        h = r[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return r;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst && cyc < N) begin
            chk("ready_out", 32'(ready_out), 32'(e_ready[cyc]));
            chk("dmem_req", 32'(dmem.req), 32'(e_req[cyc]));
            chk("valid_out", 32'(valid_out), 32'(e_valid[cyc]));
            chk("bus_err", 32'(bus_err), 32'(e_berr[cyc]));
            chk("misalign_err", 32'(misalign_err), 32'(e_mis[cyc]));
            if (e_req[cyc]) begin
                chk("dmem_addr", dmem.addr, e_addr[cyc]);
                chk("dmem_we", 32'(dmem.we), 32'(e_dwe[cyc]));
                last_addr = dmem.addr;
                if (e_dwe[cyc]) begin
                    chk("dmem_wstrb", 32'(dmem.wstrb), 32'(e_strb[cyc]));
                    chk("dmem_wdata", dmem.wdata, e_wdata[cyc]);
                    last_strb  = dmem.wstrb;
                    last_wdata = dmem.wdata;
                end
            end
            if (e_valid[cyc]) begin
                chk("rd_out", 32'(rd_out), 32'(e_rd[cyc]));
                chk("reg_we_out", 32'(reg_we_out), 32'(e_rwe[cyc]));
                if (e_wbchk[cyc]) chk("wb_data", wb_data, e_wb[cyc]);
                last_wb   = wb_data;
                last_rd   = rd_out;
                last_rwe  = reg_we_out;
                last_berr = bus_err;
                last_mis  = misalign_err;
            end
        end
    end

    // k = cycle of dmem_req on which ack is given (1-based); 0 = never acked.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic we, input int k, input logic [31:0] rdat);
        int   A, V;
        logic legal, mis, mem_go, tmo;
        @(negedge clk);
        A = cyc + 1;
        legal = ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   : (f3 inside {3'b000, 3'b001, 3'b010});
`ifdef MISALIGN_TRAP_EN
        mis = (ld || st) && legal &&
              (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
`else
        mis = 1'b0;
`endif
        mem_go = (ld || st) && legal && !mis;
        tmo    = mem_go && (k == 0 || k > WAIT);
        V = A + (mem_go ? (tmo ? WAIT : k) : 0);
        for (int c = A; c <= V; c++) e_ready[c] = 1'b0;
        for (int c = A; c < V; c++) begin
            e_req[c]   = 1'b1;
            e_addr[c]  = {a[31:2], 2'b00};
            e_dwe[c]   = st;
            e_strb[c]  = m_strb(f3, a[1:0]);
            e_wdata[c] = m_wdata(f3, sd);
        end
        e_valid[V] = 1'b1;
        e_rd[V]    = rd;
        e_berr[V]  = tmo;
        e_mis[V]   = mis;
        e_wbchk[V] = !tmo;
        if (!(ld || st))      begin e_wb[V] = a;                       e_rwe[V] = we;   end
        else if (mis)         begin e_wb[V] = a;                       e_rwe[V] = 1'b0; end
        else if (!legal || st || tmo) begin e_wb[V] = 32'h0;          e_rwe[V] = 1'b0; end
        else                  begin e_wb[V] = m_load(f3, a[1:0], rdat); e_rwe[V] = we;   end

        valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        alu_result = a; store_data = sd; rd_in = rd; reg_we_in = we;
        @(posedge clk); #1;
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
        if (mem_go && !tmo) begin
            repeat (k - 1) @(posedge clk);
            #1 dmem.ack = 1'b1; dmem.rdata = rdat;
            @(posedge clk);
            #1 dmem.ack = 1'b0; dmem.rdata = 32'h0;
        end else if (tmo) begin
            repeat (WAIT) @(posedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int A;
        for (int c = 0; c < N; c++) begin
            e_ready[c] = 1'b1; e_req[c] = 1'b0; e_dwe[c] = 1'b0; e_addr[c] = '0;
            e_strb[c] = '0; e_wdata[c] = '0; e_valid[c] = 1'b0; e_wbchk[c] = 1'b0;
            e_wb[c] = '0; e_rd[c] = '0; e_rwe[c] = 1'b0; e_berr[c] = 1'b0; e_mis[c] = 1'b0;
        end
        rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        alu_result = '0; store_data = '0; rd_in = '0; reg_we_in = 1'b0;
        dmem.ack = 1'b0; dmem.rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_wb", wb_data, 32'h0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        chk("rst_rwe", 32'(reg_we_out), 32'd0);
        chk_en = 1'b1;

        run_op(0, 0, 3'b000, 32'h0000_1234, 0, 5'd5, 1'b1, 0, 0);
        chk("nonmem_wb", last_wb, 32'h1234);
        chk("nonmem_rd", 32'(last_rd), 32'd5);

        run_op(1, 0, 3'b000, 32'h0000_0103, 0, 5'd7, 1'b1, 2, 32'h80FF_0000);
        chk("lb_wb", last_wb, 32'hFFFF_FF80);
        chk("lb_addr", last_addr, 32'h100);

        run_op(1, 0, 3'b101, 32'h0000_0202, 0, 5'd8, 1'b1, 1, 32'h8001_AAAA);
        chk("lhu_wb", last_wb, 32'h0000_8001);

        run_op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0, 1'b0, 3, 0);
        chk("sh_strb", 32'(last_strb), 32'hC);
        chk("sh_wdata", last_wdata, 32'h1234_1234);
        chk("sh_rwe", 32'(last_rwe), 32'd0);

        run_op(1, 0, 3'b001, 32'h0000_0004, 0, 5'd9, 1'b1, 1, 32'h1234_8765);
        run_op(0, 1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 5'd0, 1'b0, 1, 0);
        chk("sb_strb", 32'(last_strb), 32'h2);
        run_op(1, 0, 3'b010, 32'h0000_0020, 0, 5'd10, 1'b1, 2, 32'hCAFE_F00D);
        run_op(1, 0, 3'b100, 32'h0000_0002, 0, 5'd11, 1'b1, 1, 32'h00A5_0000);
        chk("lbu_wb", last_wb, 32'h0000_00A5);

        run_op(1, 0, 3'b010, 32'h0000_0030, 0, 5'd12, 1'b1, 0, 0);
        chk("tmo_berr", 32'(last_berr), 32'd1);
        chk("tmo_rwe", 32'(last_rwe), 32'd0);
        run_op(1, 0, 3'b010, 32'h0000_0034, 0, 5'd13, 1'b1, WAIT, 32'h0000_0055);
        chk("ack_last_berr", 32'(last_berr), 32'd0);
        chk("ack_last_wb", last_wb, 32'h55);

        run_op(1, 0, 3'b011, 32'h0000_0040, 0, 5'd14, 1'b1, 1, 0);
        run_op(0, 1, 3'b100, 32'h0000_0040, 32'h1, 5'd0, 1'b0, 1, 0);
        chk("illegal_st_wb", last_wb, 32'h0);
        run_op(1, 0, 3'b010, 32'h0000_0040, 0, 5'd0, 1'b1, 1, 32'h0000_0777);
        chk("ld_x0_rwe", 32'(last_rwe), 32'd1);

        // Stray ack with no request outstanding must have no effect.
        @(negedge clk); dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
        @(negedge clk); dmem.ack = 1'b0; dmem.rdata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset while a request is outstanding.
        @(negedge clk);
        A = cyc + 1;
        for (int c = A; c <= A + 1; c++) begin
            e_ready[c] = 1'b0; e_req[c] = 1'b1; e_addr[c] = 32'h50; e_dwe[c] = 1'b0;
        end
        valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h50; rd_in = 5'd3;
        reg_we_in = 1'b1;
        @(posedge clk); #1 valid_in = 1'b0; is_load = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rstreq_req", 32'(dmem.req), 32'd0);
        chk("rstreq_ready", 32'(ready_out), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        run_op(0, 1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1, 0);
        chk("sw_strb", 32'(last_strb), 32'hF);

        run_op(1, 0, 3'b010, 32'h0000_0006, 0, 5'd4, 1'b1, 1, 32'hCAFE_F00D);
        run_op(0, 1, 3'b001, 32'h0000_0201, 32'h0000_BEEF, 5'd0, 1'b0, 1, 0);
        run_op(1, 0, 3'b010, 32'h0000_0006, 0, 5'd4, 1'b1, 1, 32'hCAFE_F00D);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_wb", last_wb, 32'h6);
        chk("lw_mis_flag", 32'(last_mis), 32'd1);
`else
        chk("lw_unal_wb", last_wb, 32'hCAFE_F00D);
        chk("lw_unal_addr", last_addr, 32'h4);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
